// File: rtl/dekatron_pkg.sv
// Shared types for the dekatron step sequencer: FSM state encoding and request direction codes.
package dekatron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/dekatron_step_sequencer_if.sv
// Request handshake and pulse outputs of the step sequencer.
// SHADOW is present only when DEKATRON_SHADOW_COUNT_EN is defined.
interface dekatron_step_sequencer_if #(
    parameter int PEND_W = 4
`ifdef DEKATRON_SHADOW_COUNT_EN
    , parameter int WIDTH = 8
`endif
);
    logic                     req_valid;
    logic                     req_dir;
    logic                     req_ready;
    logic                     up;
    logic                     down;
    logic                     busy;
    logic signed [PEND_W-1:0] pending;
`ifdef DEKATRON_SHADOW_COUNT_EN
    logic [WIDTH-1:0]         shadow;

    modport master (output req_valid, req_dir,
                    input  req_ready, up, down, busy, pending, shadow);
    modport slave  (input  req_valid, req_dir,
                    output req_ready, up, down, busy, pending, shadow);
`else
    modport master (output req_valid, req_dir,
                    input  req_ready, up, down, busy, pending);
    modport slave  (input  req_valid, req_dir,
                    output req_ready, up, down, busy, pending);
`endif
endinterface

// File: rtl/dekatron_step_sequencer_step_timer.sv
// Loadable down-counter timing both the pulse and the gap phases; done at terminal count zero.
module step_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/dekatron_step_sequencer.sv
// Nets inc/dec requests into a signed pending count and emits fixed-width, gapped UP/DOWN pulses.
// Optional predicted downstream count enabled by DEKATRON_SHADOW_COUNT_EN.
//
//   state | meaning
//   IDLE  | nothing in flight; dispatch as soon as pending != 0
//   PULSE | UP or DOWN held high for PULSE_CYCLES
//   GAP   | both low for GAP_CYCLES, then dispatch again or go idle
module dekatron_step_sequencer
    import dekatron_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int PEND_MAX     = 7,
    parameter int PEND_W       = 4
`ifdef DEKATRON_SHADOW_COUNT_EN
    , parameter int WIDTH      = 8
    , parameter int MAX_VALUE  = 255
`endif
) (
    input  logic                      CLK,
    input  logic                      RST,
    dekatron_step_sequencer_if.slave  bus
);
    localparam int MAXC  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TMR_W-1:0]        PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]        GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic signed [PEND_W-1:0] PEND_POS  = PEND_W'(PEND_MAX);
    localparam logic signed [PEND_W-1:0] PEND_NEG  = -PEND_POS;
    localparam logic signed [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_e                   state_q, state_d;
    logic signed [PEND_W-1:0] pending_q, pending_d;
    logic                     up_q, up_d, down_q, down_d;
    logic                     req_ready;
    logic                     acc_up, acc_dn, disp_up, disp_dn, can_dispatch;
    logic                     tmr_load, tmr_done;
    logic [TMR_W-1:0]         tmr_val;

    step_timer #(.W(TMR_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        req_ready = 1'b0;
        if (!RST) begin
            req_ready = !((bus.req_dir == DIR_UP   && pending_q == PEND_POS) ||
                          (bus.req_dir == DIR_DOWN && pending_q == PEND_NEG));
        end
    end

    assign acc_up = bus.req_valid && req_ready && (bus.req_dir == DIR_UP);
    assign acc_dn = bus.req_valid && req_ready && (bus.req_dir == DIR_DOWN);

    always_comb begin
        state_d      = state_q;
        up_d         = up_q;
        down_d       = down_q;
        tmr_load     = 1'b0;
        tmr_val      = PULSE_LOAD;
        disp_up      = 1'b0;
        disp_dn      = 1'b0;
        can_dispatch = 1'b0;
        case (state_q)
            IDLE:  can_dispatch = 1'b1;
            PULSE: if (tmr_done) begin
                       state_d  = GAP;
                       up_d     = 1'b0;
                       down_d   = 1'b0;
                       tmr_load = 1'b1;
                       tmr_val  = GAP_LOAD;
                   end
            GAP:   if (tmr_done) begin
                       state_d      = IDLE;
                       can_dispatch = 1'b1;
                   end
            default: state_d = IDLE;
        endcase
        // Dispatch looks at the registered pending, never at this cycle's accepts.
        if (can_dispatch && pending_q != '0) begin
            state_d  = PULSE;
            tmr_load = 1'b1;
            tmr_val  = PULSE_LOAD;
            if (!pending_q[PEND_W-1]) begin
                up_d    = 1'b1;
                disp_up = 1'b1;
            end else begin
                down_d  = 1'b1;
                disp_dn = 1'b1;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (acc_up)  pending_d = pending_d + PEND_ONE;
        if (acc_dn)  pending_d = pending_d - PEND_ONE;
        if (disp_up) pending_d = pending_d - PEND_ONE;
        if (disp_dn) pending_d = pending_d + PEND_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= '0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            up_q      <= up_d;
            down_q    <= down_d;
        end
    end

`ifdef DEKATRON_SHADOW_COUNT_EN
    localparam logic [WIDTH-1:0] SHADOW_MAX = WIDTH'(MAX_VALUE);
    logic [WIDTH-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (disp_up) begin
            shadow_d = (shadow_q == SHADOW_MAX) ? '0 : shadow_q + WIDTH'(1);
        end else if (disp_dn) begin
            shadow_d = (shadow_q == '0) ? SHADOW_MAX : shadow_q - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign bus.shadow = shadow_q;
`endif

    assign bus.req_ready = req_ready;
    assign bus.up        = up_q;
    assign bus.down      = down_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = (state_q != IDLE) || (pending_q != '0);
endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Scoreboard bench for dekatron_step_sequencer; shadow checks run when DEKATRON_SHADOW_COUNT_EN is defined.
module tb_dekatron_step_sequencer;
    localparam int PULSE  = 4;
    localparam int GAPC   = 4;
    localparam int STEP   = PULSE + GAPC;
    localparam int PEND_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DEKATRON_SHADOW_COUNT_EN
    dekatron_step_sequencer_if #(.PEND_W(PEND_W), .WIDTH(8)) bus ();
`else
    dekatron_step_sequencer_if #(.PEND_W(PEND_W)) bus ();
`endif

    dekatron_step_sequencer dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic dir;
        int   start;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input int s);
        exp_t x;
        x.dir   = d;
        x.start = s;
        exp_q.push_back(x);
    endtask

    // One-cycle request; acc returns the edge at which it is taken.
    task automatic req(input logic d, input int exp_rdy, output int acc);
        bus.req_valid = 1'b1;
        bus.req_dir   = d;
        #1;
        check("req_ready", int'(bus.req_ready), exp_rdy);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_cyc, input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            tick();
            n++;
        end
        check({name, "_busy"}, int'(bus.busy), 0);
        if (exp_cyc >= 0) check({name, "_idle_cyc"}, cyc, exp_cyc);
    endtask

    // Pulse monitor: pops an expectation on every rising UP/DOWN.
    logic prev_up = 1'b0, prev_dn = 1'b0, in_pulse = 1'b0;
    int   rise_cyc = 0, fall_cyc = -100;

    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
            fall_cyc = -100;
        end else begin
            if ((bus.up && !prev_up) || (bus.down && !prev_dn)) begin
                check("no_overlap", int'(bus.up && bus.down), 0);
                check("gap_ok", int'((cyc - fall_cyc) >= GAPC), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got dir %0d at cycle %0d, expected no pulse", bus.down, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_dir", int'(bus.down), int'(e.dir));
                    if (e.start >= 0) check("pulse_start", cyc, e.start);
                end
                in_pulse = 1'b1;
                rise_cyc = cyc;
            end
            if (in_pulse && !bus.up && !bus.down) begin
                check("pulse_width", cyc - rise_cyc, PULSE);
                in_pulse = 1'b0;
                fall_cyc = cyc;
            end
        end
        prev_up = bus.up;
        prev_dn = bus.down;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a, a0;
        bus.req_valid = 1'b1;
        bus.req_dir   = 1'b0;
        repeat (3) tick();
        check("rst_ready", int'(bus.req_ready), 0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("rst_up", int'(bus.up), 0);
        check("rst_down", int'(bus.down), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_pending", int'(bus.pending), 0);
        tick();

        // Single UP step.
        req(1'b0, 1, a);
        push(1'b0, a + 1);
        check("t1_pending_acc", int'(bus.pending), 1);
        tick();
        check("t1_up", int'(bus.up), 1);
        check("t1_down", int'(bus.down), 0);
        check("t1_pending_disp", int'(bus.pending), 0);
        wait_idle("t1", a + 9, 40);
        tick();

        // Five back-to-back UP requests.
        for (int k = 0; k < 5; k++) begin
            req(1'b0, 1, a);
            if (k == 0) a0 = a;
            push(1'b0, a0 + 1 + STEP * k);
        end
        check("t2_pending_peak", int'(bus.pending), 4);
        wait_idle("t2", a0 + 41, 80);
        tick();

        // Fill to +7, then cancel three with DOWN requests.
        for (int k = 0; k < 8; k++) begin
            req(1'b0, 1, a);
            if (k == 0) a0 = a;
            if (k < 5) push(1'b0, a0 + 1 + STEP * k);
        end
        check("t3_pending_full", int'(bus.pending), 7);
        bus.req_dir = 1'b0;
        #1;
        check("t3_ready_up_full", int'(bus.req_ready), 0);
        bus.req_dir = 1'b1;
        #1;
        check("t3_ready_dn_full", int'(bus.req_ready), 1);
        req(1'b1, 1, a);
        bus.req_dir = 1'b0;
        #1;
        check("t3_ready_up_back", int'(bus.req_ready), 1);
        req(1'b1, 1, a);
        req(1'b1, 1, a);
        check("t3_pending_net", int'(bus.pending), 3);
        wait_idle("t3", a0 + 41, 80);
        tick();

        // DOWN accepted in the same edge an UP is dispatched.
        req(1'b0, 1, a0);
        push(1'b0, a0 + 1);
        req(1'b1, 1, a);
        push(1'b1, a0 + 9);
        check("t4_pending_neg", int'(bus.pending), -1);
        wait_idle("t4", a0 + 17, 40);
        tick();

        // Reset in the 2nd cycle of a pulse while pending is 3.
        for (int k = 0; k < 5; k++) begin
            req(1'b0, 1, a);
            if (k == 0) a0 = a;
            if (k < 2) push(1'b0, a0 + 1 + STEP * k);
        end
        repeat (6) tick();
        check("t5_up_before", int'(bus.up), 1);
        check("t5_pending_before", int'(bus.pending), 3);
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_dir   = 1'b0;
        #1;
        check("t5_ready_in_rst", int'(bus.req_ready), 0);
        tick();
        check("t5_up_rst", int'(bus.up), 0);
        check("t5_pending_rst", int'(bus.pending), 0);
        check("t5_busy_rst", int'(bus.busy), 0);
        tick();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        repeat (30) tick();
        check("t5_busy_after", int'(bus.busy), 0);
        check("t5_pending_after", int'(bus.pending), 0);

`ifdef DEKATRON_SHADOW_COUNT_EN
        begin
            int sent, guard;
            logic r;
            check("t6_shadow_start", int'(bus.shadow), 0);
            req(1'b1, 1, a);
            push(1'b1, a + 1);
            tick();
            check("t6_shadow_wrap_dn", int'(bus.shadow), 255);
            wait_idle("t6a", a + 9, 40);
            tick();
            req(1'b0, 1, a);
            push(1'b0, a + 1);
            tick();
            check("t6_shadow_wrap_up", int'(bus.shadow), 0);
            sent  = 1;
            guard = 0;
            bus.req_dir   = 1'b0;
            bus.req_valid = 1'b1;
            while (sent < 256 && guard < 4000) begin
                r = bus.req_ready;
                @(posedge clk);
                #1;
                if (r) begin
                    sent++;
                    push(1'b0, -1);
                end
                guard++;
            end
            bus.req_valid = 1'b0;
            check("t6_sent", sent, 256);
            wait_idle("t6b", -1, 4000);
            check("t6_shadow_end", int'(bus.shadow), 255);
        end
`endif

        repeat (10) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
